// File: rtl/alu4_sequencer.sv
// alu4_sequencer: micro-sequencer that stores a short program of
// {opcode, imm} words and runs it one instruction per clock against a 4-bit
// accumulator, using an external combinational ALU for all arithmetic.
module alu4_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [7:0]    prog_instr,
  input  logic          prog_clear,
  input  logic          start,
  input  logic [3:0]    acc_init,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_opcode,
  input  logic [3:0]    alu_out,
  input  logic          alu_z,
  input  logic          alu_c,
  output logic          busy,
  output logic          done,
  output logic [3:0]    acc,
  output logic [1:0]    flags,
  output logic [AW:0]   prog_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   pc;
  logic [7:0]      cur_instr;
  logic            in_idle;
  logic            in_run;
  logic            wr_en;
  logic            last_instr;

  assign in_idle    = (state == S_IDLE);
  assign in_run     = (state == S_RUN);
  assign cur_instr  = mem[pc];

  // Loading is only possible while idle, with room left, and when neither of
  // the higher-priority commands (clear, start) is being presented.
  assign prog_ready = in_idle && (prog_count < DEPTH_C) && !start && !prog_clear;
  assign wr_en      = prog_valid && prog_ready;

  // The instruction at pc is the final one of the stored program.
  assign last_instr = ({1'b0, pc} == (prog_count - ONE_C));

  // ALU operand drive: the current instruction only while running, idle-zero otherwise.
  assign alu_a      = acc;
  assign alu_b      = in_run ? cur_instr[3:0] : 4'h0;
  assign alu_opcode = in_run ? cur_instr[7:4] : 4'h0;

  // Program store write port.
  // NOTE: the program memory has no reset; only the fill count is cleared, so
  // stale words are never read and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_count[AW-1:0]] <= prog_instr;
    end
  end

  // Control FSM with registered busy/done, accumulator, flags and counters.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= 4'h0;
      flags      <= 2'b00;
      prog_count <= '0;
      pc         <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (prog_clear) begin
            prog_count <= '0;
          end else if (start) begin
            acc   <= acc_init;
            flags <= 2'b00;
            pc    <= '0;
            busy  <= 1'b1;
            if (prog_count != '0) begin
              state <= S_RUN;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (wr_en) begin
            prog_count <= prog_count + ONE_C;
          end
        end

        S_RUN: begin
          acc   <= alu_out;
          flags <= {alu_c, alu_z};
          pc    <= pc + 1'b1;
          if (last_instr) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_sequencer.sv
// Testbench for alu4_sequencer: a behavioural 4-bit ALU drives the ALU
// inputs, table vectors and random programs are checked against a reference
// model that replays the program as a simple list of ALU operations.
module tb_alu4_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rst_n;
  logic          prog_valid;
  logic          prog_ready;
  logic [7:0]    prog_instr;
  logic          prog_clear;
  logic          start;
  logic [3:0]    acc_init;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [3:0]    alu_opcode;
  logic [3:0]    alu_out;
  logic          alu_z;
  logic          alu_c;
  logic          busy;
  logic          done;
  logic [3:0]    acc;
  logic [1:0]    flags;
  logic [AW:0]   prog_count;

  int checks = 0;
  int errors = 0;

  alu4_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_instr (prog_instr),
    .prog_clear (prog_clear),
    .start      (start),
    .acc_init   (acc_init),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .busy       (busy),
    .done       (done),
    .acc        (acc),
    .flags      (flags),
    .prog_count (prog_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit ALU: returns {c, z, out[3:0]}.
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    s = 5'd0;
    c = 1'b0;
    case (op)
      4'h0: r = a;
      4'h1: r = a & b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h4: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      4'h5: begin s = {1'b0, a} + 5'd1;      r = s[3:0]; c = s[4]; end
      4'h6: begin r = a - b;    c = (a < b);  end
      4'h7: begin r = a - 4'd1; c = (a == 4'd0); end
      4'h8: r = ~a;
      4'h9: begin r = {a[2:0], 1'b0}; c = a[3]; end
      4'hA: begin r = {1'b0, a[3:1]}; c = a[0]; end
      4'hB: r = {3'b000, (a == b)};
      4'hC: r = {3'b000, (a < b)};
      4'hD: r = b;
      4'hE: r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return {c, (r == 4'h0), r};
  endfunction

  // External combinational ALU attached to the sequencer.
  always_comb begin
    logic [5:0] res;
    res = alu_f(alu_a, alu_b, alu_opcode);
    alu_out = res[3:0];
    alu_z   = res[4];
    alu_c   = res[5];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: replay the program as a plain sequence of ALU operations.
  task automatic ref_run(input logic [63:0] prog, input int n, input logic [3:0] init,
                         output logic [3:0] r_acc, output logic [1:0] r_flags);
    logic [5:0] res;
    r_acc   = init;
    r_flags = 2'b00;
    for (int i = 0; i < n; i++) begin
      res     = alu_f(r_acc, prog[8*i +: 4], prog[8*i+4 +: 4]);
      r_acc   = res[3:0];
      r_flags = {res[5], res[4]};
    end
  endtask

  task automatic load_prog(input logic [63:0] prog, input int n);
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_instr = prog[8*i +: 8];
      @(negedge clk);
    end
    prog_valid = 1'b0;
    check("load_count", 32'(prog_count), 32'(n));
  endtask

  // Start a run and follow it to done. Checks the ALU drive each RUN cycle
  // against the program word and the model accumulator. With poke set, start
  // and prog_valid are thrown at the DUT mid-run.
  task automatic run_prog(input logic [63:0] prog, input int n, input logic [3:0] init,
                          input bit poke, output logic [3:0] acc_o,
                          output logic [1:0] flags_o, output int k);
    logic [3:0] m_acc;
    logic [5:0] res;
    logic [3:0] cnt_before;
    m_acc      = init;
    cnt_before = 4'(prog_count);
    acc_init   = init;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      if (k < n) begin
        check("run_opcode", 32'(alu_opcode), 32'(prog[8*k+4 +: 4]));
        check("run_b", 32'(alu_b), 32'(prog[8*k +: 4]));
        check("run_a", 32'(alu_a), 32'(m_acc));
        res   = alu_f(m_acc, prog[8*k +: 4], prog[8*k+4 +: 4]);
        m_acc = res[3:0];
      end
      if (poke && k == 1) begin
        start      = 1'b1;
        prog_valid = 1'b1;
        prog_instr = 8'h5F;
        #1 check("ready_in_run", 32'(prog_ready), 32'd0);
      end else begin
        start      = 1'b0;
        prog_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start      = 1'b0;
    prog_valid = 1'b0;
    if (!done) check("done_timeout", 32'(done), 32'd1);
    if (n == 0) begin
      check("empty_opcode", 32'(alu_opcode), 32'd0);
      check("empty_b", 32'(alu_b), 32'd0);
    end
    check("busy_at_done", 32'(busy), 32'd1);
    acc_o   = acc;
    flags_o = flags;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("count_retained", 32'(prog_count), 32'(cnt_before));
  endtask

  typedef struct {
    logic [63:0] prog;
    int          n;
    logic [3:0]  init;
    logic [3:0]  exp_acc;
    logic [1:0]  exp_flags;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_acc;
    logic [1:0]  r_flags;
    logic [3:0]  g_acc;
    logic [1:0]  g_flags;
    logic [63:0] prog;
    int          k;
    int          n;
    int          accepted;

    // Expected results worked out by hand from the ALU opcode map above.
    vecs[0] = '{64'h5143,             2, 4'h4, 4'h8, 2'b00}; // ADD 3, INC
    vecs[1] = '{64'h41,               1, 4'hF, 4'h0, 2'b11}; // ADD 1 wraps
    vecs[2] = '{64'h65,               1, 4'h3, 4'hE, 2'b10}; // SUB 5 borrows
    vecs[3] = '{64'hB7,               1, 4'h7, 4'h1, 2'b00}; // CMP_EQ true
    vecs[4] = '{64'h903F,             2, 4'hA, 4'hA, 2'b00}; // XOR F, SHL
    vecs[5] = '{64'h10,               1, 4'h5, 4'h0, 2'b01}; // AND 0
    vecs[6] = '{64'h0,                0, 4'h9, 4'h9, 2'b00}; // empty program
    vecs[7] = '{64'h5151515151515151, 8, 4'h9, 4'h1, 2'b00}; // 8x INC, full

    rst_n      = 1'b0;
    prog_valid = 1'b0;
    prog_instr = 8'h00;
    prog_clear = 1'b0;
    start      = 1'b0;
    acc_init   = 4'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_count", 32'(prog_count), 32'd0);
    check("rst_ready", 32'(prog_ready), 32'd1);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven programs.
    foreach (vecs[i]) begin
      load_prog(vecs[i].prog, vecs[i].n);
      run_prog(vecs[i].prog, vecs[i].n, vecs[i].init, 1'b0, g_acc, g_flags, k);
      check($sformatf("vec%0d_acc", i), 32'(g_acc), 32'(vecs[i].exp_acc));
      check($sformatf("vec%0d_flags", i), 32'(g_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].n));
    end

    // Re-run of the retained 8x INC program from a different start value.
    run_prog(vecs[7].prog, 8, 4'h0, 1'b0, g_acc, g_flags, k);
    check("rerun_acc", 32'(g_acc), 32'h8);
    check("rerun_flags", 32'(g_flags), 32'd0);

    // Start and program offers during RUN are ignored.
    load_prog(64'h515151, 3);
    run_prog(64'h515151, 3, 4'h2, 1'b1, g_acc, g_flags, k);
    check("poke_acc", 32'(g_acc), 32'h5);
    check("poke_latency", 32'(k), 32'd3);
    check("poke_busy_idle", 32'(busy), 32'd0);

    // Overflow: 9 words back-to-back, only DEPTH accepted.
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
    accepted   = 0;
    for (int i = 0; i < 9; i++) begin
      prog_valid = 1'b1;
      prog_instr = 8'(i);
      #1;
      if (prog_ready) accepted++;
      if (i == 8) check("ovf_ready_9th", 32'(prog_ready), 32'd0);
      @(negedge clk);
    end
    prog_valid = 1'b0;
    check("ovf_accepted", 32'(accepted), 32'd8);
    check("ovf_count", 32'(prog_count), 32'd8);
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
    #1;
    check("clear_count", 32'(prog_count), 32'd0);
    check("clear_ready", 32'(prog_ready), 32'd1);

    // prog_clear wins over start in the same cycle.
    load_prog(64'h5151, 2);
    prog_clear = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
    start      = 1'b0;
    check("clrstart_busy", 32'(busy), 32'd0);
    check("clrstart_done", 32'(done), 32'd0);
    check("clrstart_count", 32'(prog_count), 32'd0);

    // Reset during the second RUN cycle.
    load_prog(64'h51515151, 4);
    acc_init = 4'h0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 check("midrun_acc_pre", 32'(acc), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_acc", 32'(acc), 32'd0);
    check("midrun_count", 32'(prog_count), 32'd0);
    accepted = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) accepted++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) accepted++;
    end
    check("midrun_no_done", 32'(accepted), 32'd0);

    // Randomized programs against the reference model.
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, DEPTH);
      prog = {$urandom(), $urandom()};
      acc_init = 4'($urandom());
      load_prog(prog, n);
      ref_run(prog, n, acc_init, r_acc, r_flags);
      run_prog(prog, n, acc_init, 1'b0, g_acc, g_flags, k);
      check("rand_acc", 32'(g_acc), 32'(r_acc));
      check("rand_flags", 32'(g_flags), 32'(r_flags));
      check("rand_latency", 32'(k), 32'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
